div_sequencer: RTL
==================

# div_sequencer

Multi-cycle divide controller for the execute stage. It sequences an iterative radix-2 restoring divider for DIV/DIVU and raises `stall_divE` toward the hazard unit while the quotient is being computed. It produces the HI/LO result in the cycle the stall releases, so the divide instruction leaves E carrying its result. It supports cancellation when the E-stage instruction is annulled by an exception flush.

## Interface
Parameters:
- `WIDTH`, 32, operand width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  pipeline clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `div_startE`  in  1  divide instruction is valid in E this cycle.
- `div_signedE`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `srcaE`  in  WIDTH  dividend (rs value after forwarding).
- `srcbE`  in  WIDTH  divisor (rt value after forwarding).
- `div_cancel`  in  1  abort the current operation (E-stage instruction annulled).
- `stall_divE`  out  1  stall request to the hazard unit; combinational.
- `div_validE`  out  1  one-cycle pulse: `hiE`/`loE` hold a new result.
- `hiE`  out  WIDTH  remainder, registered.
- `loE`  out  WIDTH  quotient, registered.

## Operation
- States: IDLE, BUSY, DONE. Reset enters IDLE, clears the counter and working registers, and sets `hiE`=`loE`=0, `div_validE`=0, `stall_divE`=0.
- IDLE: when `div_startE` & !`div_cancel`:
  - Latch the operand magnitudes. If signed and the MSB is set, store the two's-complement negation; otherwise store the raw value.
  - Latch the quotient sign (sa^sb, signed only) and the remainder sign (sa, signed only).
  - If divisor = 0, go to DONE. Otherwise go to BUSY with counter = 0.
- BUSY: perform one restoring step per cycle:
  - Shift {rem, quo} left 1.
  - Trial subtract the divisor from rem. If no borrow, keep the difference and set the quotient LSB to 1.
  - Increment the counter. After step `WIDTH`-1 (counter = `WIDTH`-1), go to DONE.
- DONE: `div_validE`=1 for exactly one cycle. Always return to IDLE next cycle, even though `div_startE` is still high that cycle (same instruction leaving E). The operation must not restart.
- Result fixup, registered into `hiE`/`loE` on the BUSY→DONE edge:
  - `loE` = quotient negated if the quotient sign is set.
  - `hiE` = remainder negated if the remainder sign is set.
  - All arithmetic is modulo 2^`WIDTH`.
- Divide by zero, on the IDLE→DONE edge: `loE` = all ones, `hiE` = raw `srcaE`. Signedness is ignored.
- Overflow case: 0x80000000 / 0xFFFFFFFF signed produces `loE`=0x80000000, `hiE`=0 by natural wrap. No special handling.
- `stall_divE` = (IDLE & `div_startE` & !`div_cancel`) | BUSY. It is low in DONE.
- `div_cancel` in any state: next state is IDLE, and `stall_divE` is low in that same cycle. `hiE`/`loE` keep their previous values, and `div_validE` is not asserted. Cancel takes priority over start and over completion.
- `hiE`/`loE` hold their value until the next completed operation.

## Timing
- Cycle 0: start accepted in IDLE; `stall_divE`=1 combinationally in the same cycle.
- Cycles 1..`WIDTH`: BUSY, `stall_divE`=1.
- Cycle `WIDTH`+1: DONE, `stall_divE`=0, `div_validE`=1, result valid.
- Total stall is `WIDTH`+1 = 33 cycles, and the result is available 33 cycles after start.
- Divide by zero: stall for cycle 0 only; DONE in cycle 1.
- Back-to-back: a new `div_startE` is accepted in the IDLE cycle immediately following DONE, so there is no dead cycle beyond DONE.
- Asynchronous `rst` mid-operation:
  - Outputs go immediately to their reset values and the state goes to IDLE.
  - After deassertion, a still-high `div_startE` is treated as a new start.
- The counter is `$clog2(WIDTH)` bits; it must not wrap in BUSY.

## Test plan
- DIVU 100 / 7: `stall_divE` high for exactly 33 cycles; in cycle 33 `loE`=14, `hiE`=2, `div_validE` pulses once.
- DIV −7 / 2 (0xFFFFFFF9 / 2): `loE`=0xFFFFFFFD, `hiE`=0xFFFFFFFF. DIV 7 / −2: `loE`=0xFFFFFFFD, `hiE`=1.
- DIV 0x80000000 / 0xFFFFFFFF: `loE`=0x80000000, `hiE`=0. DIVU 0x12345678 / 0: DONE in cycle 1, `loE`=0xFFFFFFFF, `hiE`=0x12345678.
- Start DIVU 50/5, then assert `div_cancel` in BUSY cycle 10:
  - `stall_divE` low in that cycle; IDLE next cycle; `hiE`/`loE` keep the prior result; no `div_validE`.
- Two consecutive divides (9/4, then 20/3) with `div_startE` held through DONE:
  - First result 2 r 1 in cycle 33, and no restart in that DONE cycle.
  - Second op starts in cycle 34, giving 6 r 2 in cycle 67.
- Assert `rst` in BUSY cycle 15: `stall_divE`, `hiE`, `loE` go to 0 asynchronously; a subsequent 8/2 completes normally with 4 r 0.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer
//   Multi-cycle divide controller for the execute stage. Sequences a radix-2
//   restoring divider (one quotient bit per cycle) for DIV/DIVU, stalls the
//   pipeline while the quotient is being formed, and presents HI/LO in the
//   cycle the stall releases so the divide leaves E carrying its result.
//
// Ports
//   clk, rst      pipeline clock, asynchronous active-high reset
//   div_startE    divide instruction valid in E
//   div_signedE   1 = DIV (two's complement), 0 = DIVU
//   srcaE, srcbE  dividend / divisor after forwarding
//   div_cancel    E-stage instruction annulled; abort in any state
//   stall_divE    stall request to the hazard unit (combinational)
//   div_validE    one-cycle pulse, hiE/loE hold a new result
//   hiE, loE      remainder / quotient, registered, held until next result
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_startE,
   input  logic             div_signedE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             div_cancel,
   output logic             stall_divE,
   output logic             div_validE,
   output logic [WIDTH-1:0] hiE,
   output logic [WIDTH-1:0] loE
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

   stateT            state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] remReg;
   logic [WIDTH-1:0] quoReg;
   logic [WIDTH-1:0] divisorReg;
   logic             quoNeg;
   logic             remNeg;
   logic             validReg;

   logic             accept;
   logic             aNeg;
   logic             bNeg;
   logic [WIDTH-1:0] aMag;
   logic [WIDTH-1:0] bMag;
   logic [WIDTH:0]   remShift;
   logic [WIDTH-1:0] remNext;
   logic [WIDTH-1:0] quoNext;
   logic             lastStep;

   assign accept = (state == IDLE) && div_startE && !div_cancel;

   // Operate on magnitudes; signs are reapplied to the final result.
   assign aNeg = div_signedE & srcaE[WIDTH-1];
   assign bNeg = div_signedE & srcbE[WIDTH-1];
   assign aMag = aNeg ? -srcaE : srcaE;
   assign bMag = bNeg ? -srcbE : srcbE;

   // The shifted partial remainder needs one extra bit: it can reach
   // 2*divisor-1, which overflows WIDTH bits for large divisors.
   assign remShift = {remReg, quoReg[WIDTH-1]};

   always_comb begin
      remNext = remShift[WIDTH-1:0];
      quoNext = {quoReg[WIDTH-2:0], 1'b0};
      if (remShift >= {1'b0, divisorReg}) begin
         // True difference is below the divisor, so the low bits are exact.
         remNext    = remShift[WIDTH-1:0] - divisorReg;
         quoNext[0] = 1'b1;
      end
   end

   assign lastStep = (count == CW'(WIDTH - 1));

   // Reset and cancel both drop the stall in the same cycle.
   assign stall_divE = !rst && (accept || ((state == BUSY) && !div_cancel));
   assign div_validE = validReg && !div_cancel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         remReg     <= '0;
         quoReg     <= '0;
         divisorReg <= '0;
         quoNeg     <= 1'b0;
         remNeg     <= 1'b0;
         validReg   <= 1'b0;
         hiE        <= '0;
         loE        <= '0;
      end else begin
         validReg <= 1'b0;
         if (div_cancel) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (div_startE) begin
                     remReg     <= '0;
                     quoReg     <= aMag;
                     divisorReg <= bMag;
                     quoNeg     <= aNeg ^ bNeg;
                     remNeg     <= aNeg;
                     count      <= '0;
                     if (srcbE == '0) begin
                        // Divide by zero: fixed result, signedness ignored.
                        state    <= DONE;
                        validReg <= 1'b1;
                        loE      <= '1;
                        hiE      <= srcaE;
                     end else begin
                        state <= BUSY;
                     end
                  end
               end
               BUSY: begin
                  remReg <= remNext;
                  quoReg <= quoNext;
                  if (lastStep) begin
                     state    <= DONE;
                     validReg <= 1'b1;
                     loE      <= quoNeg ? -quoNext : quoNext;
                     hiE      <= remNeg ? -remNext : remNext;
                  end else begin
                     count <= count + CW'(1);
                  end
               end
               // The instruction is leaving E with its result; a start seen
               // here belongs to the same instruction and must not restart.
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
